// File: rtl/bp_update_ctrl.sv
// bp_update_ctrl
//   Sequences writes into the single-ported branch-predictor BHT. Resolved
//   branches from execute are buffered in a small FIFO and written when the
//   fetch lookup leaves the port idle, or forcibly when the FIFO is full or
//   the head has waited STARVE_MAX cycles. An invalidate request flushes the
//   FIFO and sweeps every BHT entry with valid=0.
// Ports
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_upd_valid/o_upd_ready   update handshake; i_upd_pc/_target/_taken payload
//   i_inv_req, o_inv_busy     invalidate pulse / sweep in progress
//   i_lookup_act              fetch wants the port; o_lookup_stall = denied
//   o_wr_en, o_wr_idx, o_wr_pc, o_wr_target, o_wr_taken, o_wr_vld  BHT write port
module bp_update_ctrl #(
  parameter int PC_W       = 48,
  parameter int BHT_SIZE   = 256,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8,
  localparam int IDX_W     = $clog2(BHT_SIZE)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_upd_valid,
  output logic             o_upd_ready,
  input  logic [PC_W-1:0]  i_upd_pc,
  input  logic [PC_W-1:0]  i_upd_target,
  input  logic             i_upd_taken,
  input  logic             i_inv_req,
  output logic             o_inv_busy,
  input  logic             i_lookup_act,
  output logic             o_lookup_stall,
  output logic             o_wr_en,
  output logic [IDX_W-1:0] o_wr_idx,
  output logic [PC_W-1:0]  o_wr_pc,
  output logic [PC_W-1:0]  o_wr_target,
  output logic             o_wr_taken,
  output logic             o_wr_vld
);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int AGE_W = $clog2(STARVE_MAX + 1);
  localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(STARVE_MAX);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BHT_SIZE - 1);

  typedef enum logic {S_IDLE, S_SWEEP} state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_sweep;
  logic [AW:0]      r_wptr, r_rptr;   // extra wrap bit separates full from empty
  logic [AGE_W-1:0] r_age;
  logic [PC_W-1:0]  r_pc_q  [FIFO_DEPTH];
  logic [PC_W-1:0]  r_tgt_q [FIFO_DEPTH];
  logic             r_tk_q  [FIFO_DEPTH];

  logic            w_idle, w_empty, w_full, w_force, w_pop, w_push;
  logic [PC_W-1:0] w_head_pc, w_head_tgt;
  logic            w_head_tk;

  assign w_idle     = (r_state == S_IDLE);
  assign w_empty    = (r_wptr == r_rptr);
  assign w_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_head_pc  = r_pc_q[r_rptr[AW-1:0]];
  assign w_head_tgt = r_tgt_q[r_rptr[AW-1:0]];
  assign w_head_tk  = r_tk_q[r_rptr[AW-1:0]];

  // Age is held at zero while empty, so age==MAX implies a head exists.
  assign w_force = w_full || (r_age == AGE_MAX);
  assign w_pop   = !i_reset && w_idle && !w_empty && (!i_lookup_act || w_force);
  assign w_push  = !i_reset && w_idle && !i_inv_req && !w_full && i_upd_valid;

  // Outputs are decoded from registered state plus this cycle's requests:
  // the fetch stall and the accept must answer in the same cycle they are asked.
  always_comb begin
    o_upd_ready    = 1'b0;
    o_inv_busy     = 1'b0;
    o_lookup_stall = 1'b0;
    o_wr_en        = 1'b0;
    o_wr_idx       = '0;
    o_wr_pc        = '0;
    o_wr_target    = '0;
    o_wr_taken     = 1'b0;
    o_wr_vld       = 1'b0;
    if (!i_reset) begin
      if (w_idle) begin
        o_upd_ready = !w_full && !i_inv_req;
        if (w_pop) begin
          o_wr_en        = 1'b1;
          o_wr_vld       = 1'b1;
          o_wr_idx       = w_head_pc[IDX_W+1:2];
          o_wr_pc        = w_head_pc;
          o_wr_target    = w_head_tgt;
          o_wr_taken     = w_head_tk;
          o_lookup_stall = i_lookup_act;  // only a forced write pops under lookup
        end
      end else begin
        o_inv_busy     = 1'b1;
        o_wr_en        = 1'b1;
        o_wr_idx       = r_sweep;
        o_lookup_stall = i_lookup_act;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_sweep <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_age   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_inv_req) begin
            // Pending entries would be invalidated anyway: drop them.
            r_state <= S_SWEEP;
            r_sweep <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_age   <= '0;
          end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_pop || w_empty)   r_age <= '0;
            else if (r_age != AGE_MAX) r_age <= r_age + 1'b1;
          end
        end
        S_SWEEP: begin
          // inv_req is ignored here; the counter wraps to 0 as we leave.
          r_sweep <= r_sweep + 1'b1;
          if (r_sweep == IDX_LAST) r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_pc_q[r_wptr[AW-1:0]]  <= i_upd_pc;
      r_tgt_q[r_wptr[AW-1:0]] <= i_upd_target;
      r_tk_q[r_wptr[AW-1:0]]  <= i_upd_taken;
    end
  end
endmodule

// File: tb/tb_bp_update_ctrl.sv
module tb_bp_update_ctrl;
  logic        clk = 1'b0;
  logic        reset, upd_valid, upd_taken, inv_req, lookup_act;
  logic [47:0] upd_pc, upd_target;
  logic        upd_ready, inv_busy, lookup_stall, wr_en, wr_taken, wr_vld;
  logic [7:0]  wr_idx;
  logic [47:0] wr_pc, wr_target;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bp_update_ctrl dut (
    .i_clk(clk), .i_reset(reset), .i_upd_valid(upd_valid), .o_upd_ready(upd_ready),
    .i_upd_pc(upd_pc), .i_upd_target(upd_target), .i_upd_taken(upd_taken),
    .i_inv_req(inv_req), .o_inv_busy(inv_busy), .i_lookup_act(lookup_act),
    .o_lookup_stall(lookup_stall), .o_wr_en(wr_en), .o_wr_idx(wr_idx),
    .o_wr_pc(wr_pc), .o_wr_target(wr_target), .o_wr_taken(wr_taken), .o_wr_vld(wr_vld)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Drive inputs just after a rising edge, then wait for the falling edge to sample.
  task automatic drive(input logic rst, input logic uv, input logic [47:0] pc,
                       input logic [47:0] tgt, input logic tk, input logic inv,
                       input logic look);
    @(posedge clk); #1;
    reset = rst; upd_valid = uv; upd_pc = pc; upd_target = tgt; upd_taken = tk;
    inv_req = inv; lookup_act = look;
    @(negedge clk);
  endtask

  task automatic idle(input logic look, input logic inv);
    drive(1'b0, 1'b0, 48'h0, 48'h0, 1'b0, inv, look);
  endtask

  typedef struct {
    logic rst, uv; logic [47:0] pc, tgt; logic tk, inv, look;
    logic e_rdy, e_wr, e_stall, e_busy, e_vld; logic [7:0] e_idx;
    logic [47:0] e_pc, e_tgt;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic uv, input logic [47:0] pc,
                              input logic look, input logic e_rdy, input logic e_wr,
                              input logic e_stall, input logic [7:0] e_idx,
                              input logic [47:0] e_pc);
    vec_t v;
    v.rst = rst; v.uv = uv; v.pc = pc; v.tgt = pc + 48'h10000; v.tk = pc[2];
    v.inv = 1'b0; v.look = look;
    v.e_rdy = e_rdy; v.e_wr = e_wr; v.e_stall = e_stall; v.e_busy = 1'b0;
    v.e_vld = e_wr; v.e_idx = e_idx; v.e_pc = e_pc;
    v.e_tgt = e_wr ? e_pc + 48'h10000 : 48'h0;
    return v;
  endfunction

  // Reference model: a queue of pending updates plus a sweep position.
  typedef struct { logic [47:0] pc, tgt; logic tk; } ent_t;
  ent_t m_q[$];
  int   m_age, m_sweep_idx;
  bit   m_sweeping;

  task automatic model_check_and_step();
    bit full, wr;
    logic e_rdy, e_stall, e_busy, e_vld, e_tk;
    logic [7:0] e_idx;
    logic [47:0] e_pc, e_tgt;
    ent_t n;
    full = (m_q.size() == 4);
    wr = 0; e_rdy = 0; e_stall = 0; e_busy = 0; e_vld = 0; e_tk = 0;
    e_idx = 0; e_pc = 0; e_tgt = 0;
    if (!reset) begin
      if (m_sweeping) begin
        wr = 1; e_busy = 1; e_idx = 8'(m_sweep_idx); e_stall = lookup_act;
      end else begin
        wr = (m_q.size() > 0) && (!lookup_act || full || m_age >= 8);
        e_rdy = !full && !inv_req;
        e_stall = lookup_act && wr;
        if (wr) begin
          e_vld = 1; e_pc = m_q[0].pc; e_tgt = m_q[0].tgt; e_tk = m_q[0].tk;
          e_idx = 8'((m_q[0].pc >> 2) % 256);
        end
      end
    end
    check("rnd_ready", 64'(upd_ready), 64'(e_rdy));
    check("rnd_wr_en", 64'(wr_en), 64'(wr));
    check("rnd_stall", 64'(lookup_stall), 64'(e_stall));
    check("rnd_busy", 64'(inv_busy), 64'(e_busy));
    check("rnd_idx", 64'(wr_idx), 64'(e_idx));
    check("rnd_vld", 64'(wr_vld), 64'(e_vld));
    check("rnd_pc", 64'(wr_pc), 64'(e_pc));
    check("rnd_tgt", 64'(wr_target), 64'(e_tgt));
    check("rnd_taken", 64'(wr_taken), 64'(e_tk));
    // advance model to the upcoming edge
    if (reset) begin
      m_q.delete(); m_age = 0; m_sweeping = 0; m_sweep_idx = 0;
    end else if (m_sweeping) begin
      m_sweep_idx++;
      if (m_sweep_idx == 256) begin m_sweeping = 0; m_sweep_idx = 0; end
    end else if (inv_req) begin
      m_q.delete(); m_age = 0; m_sweeping = 1; m_sweep_idx = 0;
    end else begin
      if (wr) begin void'(m_q.pop_front()); m_age = 0; end
      else if (m_q.size() > 0) m_age = (m_age < 8) ? m_age + 1 : 8;
      else m_age = 0;
      if (upd_valid && e_rdy) begin
        n.pc = upd_pc; n.tgt = upd_target; n.tk = upd_taken;
        m_q.push_back(n);
      end
    end
  endtask

  vec_t tbl[14];

  initial begin
    reset = 1; upd_valid = 0; upd_pc = 0; upd_target = 0; upd_taken = 0;
    inv_req = 0; lookup_act = 0;

    // ---- table: reset, single write, fill-to-full with ordering ----
    tbl[0]  = mk(1, 0, 48'h0,    0, 0, 0, 0, 8'h00, 48'h0);
    tbl[1]  = mk(0, 1, 48'h1000, 0, 1, 0, 0, 8'h00, 48'h0);
    tbl[2]  = mk(0, 0, 48'h0,    0, 1, 1, 0, 8'h00, 48'h1000);
    tbl[3]  = mk(0, 0, 48'h0,    0, 1, 0, 0, 8'h00, 48'h0);
    tbl[4]  = mk(0, 1, 48'h100,  1, 1, 0, 0, 8'h00, 48'h0);
    tbl[5]  = mk(0, 1, 48'h104,  1, 1, 0, 0, 8'h00, 48'h0);
    tbl[6]  = mk(0, 1, 48'h108,  1, 1, 0, 0, 8'h00, 48'h0);
    tbl[7]  = mk(0, 1, 48'h10C,  1, 1, 0, 0, 8'h00, 48'h0);
    tbl[8]  = mk(0, 1, 48'h110,  1, 0, 1, 1, 8'h40, 48'h100);
    tbl[9]  = mk(0, 0, 48'h0,    1, 1, 0, 0, 8'h00, 48'h0);
    tbl[10] = mk(0, 0, 48'h0,    0, 1, 1, 0, 8'h41, 48'h104);
    tbl[11] = mk(0, 0, 48'h0,    0, 1, 1, 0, 8'h42, 48'h108);
    tbl[12] = mk(0, 0, 48'h0,    0, 1, 1, 0, 8'h43, 48'h10C);
    tbl[13] = mk(0, 0, 48'h0,    0, 1, 0, 0, 8'h00, 48'h0);
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].rst, tbl[i].uv, tbl[i].pc, tbl[i].tgt, tbl[i].tk, tbl[i].inv, tbl[i].look);
      check($sformatf("tbl%0d_ready", i), 64'(upd_ready), 64'(tbl[i].e_rdy));
      check($sformatf("tbl%0d_wr_en", i), 64'(wr_en), 64'(tbl[i].e_wr));
      check($sformatf("tbl%0d_stall", i), 64'(lookup_stall), 64'(tbl[i].e_stall));
      check($sformatf("tbl%0d_busy", i), 64'(inv_busy), 64'(tbl[i].e_busy));
      check($sformatf("tbl%0d_vld", i), 64'(wr_vld), 64'(tbl[i].e_vld));
      check($sformatf("tbl%0d_idx", i), 64'(wr_idx), 64'(tbl[i].e_idx));
      check($sformatf("tbl%0d_pc", i), 64'(wr_pc), 64'(tbl[i].e_pc));
      check($sformatf("tbl%0d_tgt", i), 64'(wr_target), 64'(tbl[i].e_tgt));
    end

    // ---- starvation: one update behind continuous lookups ----
    drive(0, 1, 48'h2040, 48'h3000, 1, 0, 1);
    for (int i = 0; i < 8; i++) begin
      idle(1, 0);
      check($sformatf("starve_wait%0d", i), 64'(wr_en), 64'd0);
    end
    idle(1, 0);
    check("starve_wr_en", 64'(wr_en), 64'd1);
    check("starve_stall", 64'(lookup_stall), 64'd1);
    check("starve_idx", 64'(wr_idx), 64'h10);
    idle(1, 0);
    check("starve_after", 64'(wr_en), 64'd0);

    // ---- invalidate with 3 queued and an update offered ----
    for (int i = 0; i < 3; i++) drive(0, 1, 48'h500 + 48'(4 * i), 48'h1, 0, 0, 1);
    drive(0, 1, 48'h600, 48'h1, 0, 1, 1);
    check("inv_ready_low", 64'(upd_ready), 64'd0);
    for (int i = 0; i < 256; i++) begin
      idle(1, 0);
      check("sweep_idx", 64'(wr_idx), 64'(i));
      check("sweep_wr", 64'({wr_en, wr_vld, inv_busy, lookup_stall, upd_ready}), 64'b10110);
      check("sweep_pc", 64'(wr_pc), 64'd0);
    end
    idle(0, 0);
    check("sweep_done_busy", 64'(inv_busy), 64'd0);
    check("sweep_done_ready", 64'(upd_ready), 64'd1);
    check("sweep_dropped", 64'(wr_en), 64'd0);

    // ---- re-pulse mid-sweep is coalesced ----
    idle(0, 1);
    for (int i = 0; i < 256; i++) begin
      idle(0, i == 50);
      check("resweep_idx", 64'(wr_idx), 64'(i));
      check("resweep_busy", 64'(inv_busy), 64'd1);
    end
    idle(0, 0);
    check("resweep_done", 64'(inv_busy), 64'd0);

    // ---- reset mid-sweep ----
    idle(0, 1);
    for (int i = 0; i < 100; i++) idle(0, 0);
    check("rst_at_idx", 64'(wr_idx), 64'd99);
    drive(1, 0, 48'h0, 48'h0, 0, 0, 0);
    idle(0, 0);
    check("rst_abort_wr", 64'(wr_en), 64'd0);
    check("rst_abort_busy", 64'(inv_busy), 64'd0);
    check("rst_abort_ready", 64'(upd_ready), 64'd1);
    idle(0, 0);
    check("rst_fifo_empty", 64'(wr_en), 64'd0);

    // ---- randomized against the queue model ----
    m_q.delete(); m_age = 0; m_sweeping = 0; m_sweep_idx = 0;
    drive(1, 0, 48'h0, 48'h0, 0, 0, 0);
    model_check_and_step();
    for (int c = 0; c < 4000; c++) begin
      drive($urandom_range(0, 399) == 0, $urandom_range(0, 1) == 1,
            {16'($urandom), 32'($urandom)}, {16'($urandom), 32'($urandom)},
            1'($urandom), $urandom_range(0, 149) == 0, $urandom_range(0, 9) < 6);
      model_check_and_step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
